// File: rtl/alarm_multi_ch_if.sv
// Signal bundle between the alarm engine and its clock/UI logic.
// There is no valid/ready handshake: every input is a level sampled on each sec_clk rising edge.
interface alarm_multi_ch_if #(
  parameter int N_CH  = 4,
  parameter int SEC_W = 17
);
  logic [SEC_W-1:0]        cur_sec;
  logic [N_CH*SEC_W-1:0]   tar_sec;
  logic [2*N_CH-1:0]       len_s;
  logic [N_CH-1:0]         enable;
  logic                    off;
  logic                    snooze;
  logic [N_CH-1:0]         alarming;
  logic                    any_alarming;
  logic [$clog2(N_CH)-1:0] active_ch;

  modport master (
    output cur_sec, tar_sec, len_s, enable, off, snooze,
    input  alarming, any_alarming, active_ch
  );

  modport slave (
    input  cur_sec, tar_sec, len_s, enable, off, snooze,
    output alarming, any_alarming, active_ch
  );
endinterface

// File: rtl/alarm_multi_ch.sv
// N-channel alarm engine on the 1 Hz second clock, with shared off/snooze buttons.
// Define ALARM_SNOOZE_EN to build the snooze state (SNZ) and snooze counters.
module alarm_multi_ch #(
  parameter int N_CH       = 4,
  parameter int SEC_W      = 17,
  parameter int DAY_SEC    = 86400,
  parameter int LEN_UNIT   = 15,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic              sec_clk,
  input  logic              rst_n,
  alarm_multi_ch_if.slave   bus,
  output logic [2*N_CH-1:0] state_dbg
);
  localparam int CH_W = $clog2(N_CH);
  localparam int RC_W = $clog2(4*LEN_UNIT+1);
  localparam logic [SEC_W-1:0] DAY_LIM = SEC_W'(DAY_SEC);
`ifdef ALARM_SNOOZE_EN
  localparam int WT_W = $clog2(SNOOZE_SEC+1);
  localparam int SC_W = $clog2(MAX_SNOOZE+1);
  localparam logic [WT_W-1:0] WAIT_LOAD = WT_W'(SNOOZE_SEC);
  localparam logic [SC_W-1:0] SNZ_MAX   = SC_W'(MAX_SNOOZE);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RING = 2'd1,
`ifdef ALARM_SNOOZE_EN
    S_SNZ  = 2'd3,
`endif
    S_DONE = 2'd2
  } st_t;

  st_t             state    [N_CH];
  st_t             state_nx [N_CH];
  logic [RC_W-1:0] ring_cnt [N_CH];
  logic [RC_W-1:0] ring_nx  [N_CH];
`ifdef ALARM_SNOOZE_EN
  logic [WT_W-1:0] wait_cnt [N_CH];
  logic [WT_W-1:0] wait_nx  [N_CH];
  logic [SC_W-1:0] snz_cnt  [N_CH];
  logic [SC_W-1:0] snz_nx   [N_CH];
`endif

  logic [N_CH-1:0] alarm_q, alarm_nx;
  logic            any_q, any_nx;
  logic [CH_W-1:0] active_q, active_nx;

  // Ring window holds len+1 edges: loaded with len, expires on the edge it reads 0.
  function automatic logic [RC_W-1:0] ring_len(input logic [1:0] code);
    return RC_W'((int'(code) + 1) * LEN_UNIT);
  endfunction

  always_ff @(posedge sec_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        state[i]    <= S_IDLE;
        ring_cnt[i] <= '0;
`ifdef ALARM_SNOOZE_EN
        wait_cnt[i] <= '0;
        snz_cnt[i]  <= '0;
`endif
      end
      alarm_q  <= '0;
      any_q    <= 1'b0;
      active_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state[i]    <= state_nx[i];
        ring_cnt[i] <= ring_nx[i];
`ifdef ALARM_SNOOZE_EN
        wait_cnt[i] <= wait_nx[i];
        snz_cnt[i]  <= snz_nx[i];
`endif
      end
      alarm_q  <= alarm_nx;
      any_q    <= any_nx;
      active_q <= active_nx;
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_nx[i] = state[i];
      ring_nx[i]  = ring_cnt[i];
`ifdef ALARM_SNOOZE_EN
      wait_nx[i]  = wait_cnt[i];
      snz_nx[i]   = snz_cnt[i];
`endif
      if (!bus.enable[i]) begin
        state_nx[i] = S_IDLE;
      end else begin
        case (state[i])
          S_IDLE: begin
            if (bus.cur_sec == bus.tar_sec[i*SEC_W +: SEC_W] &&
                bus.tar_sec[i*SEC_W +: SEC_W] < DAY_LIM) begin
              state_nx[i] = S_RING;
              ring_nx[i]  = ring_len(bus.len_s[2*i +: 2]);
`ifdef ALARM_SNOOZE_EN
              snz_nx[i]   = '0;
`endif
            end
          end
          S_RING: begin
            // off wins over snooze; expiry wins over snooze
            if (bus.off || ring_cnt[i] == '0) begin
              state_nx[i] = S_DONE;
`ifdef ALARM_SNOOZE_EN
            end else if (bus.snooze && snz_cnt[i] < SNZ_MAX) begin
              state_nx[i] = S_SNZ;
              wait_nx[i]  = WAIT_LOAD;
              snz_nx[i]   = snz_cnt[i] + SC_W'(1);
`endif
            end else begin
              ring_nx[i] = ring_cnt[i] - RC_W'(1);
            end
          end
`ifdef ALARM_SNOOZE_EN
          S_SNZ: begin
            if (bus.off) begin
              state_nx[i] = S_DONE;
            end else if (wait_cnt[i] == '0) begin
              state_nx[i] = S_RING;
              ring_nx[i]  = ring_len(bus.len_s[2*i +: 2]);
            end else begin
              wait_nx[i] = wait_cnt[i] - WT_W'(1);
            end
          end
`endif
          S_DONE: begin
            if (bus.cur_sec != bus.tar_sec[i*SEC_W +: SEC_W]) state_nx[i] = S_IDLE;
          end
          default: state_nx[i] = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    alarm_nx  = '0;
    active_nx = '0;
    for (int i = 0; i < N_CH; i++) alarm_nx[i] = (state_nx[i] == S_RING);
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (alarm_nx[i]) active_nx = CH_W'(i);
    end
    any_nx = |alarm_nx;
  end

  always_comb begin
    state_dbg = '0;
    for (int i = 0; i < N_CH; i++) state_dbg[2*i +: 2] = state[i];
  end

  assign bus.alarming     = alarm_q;
  assign bus.any_alarming = any_q;
  assign bus.active_ch    = active_q;
endmodule

// File: tb/tb_alarm_multi_ch.sv
// Directed bench for alarm_multi_ch: driver queues expected outputs per edge, monitor compares.
module tb_alarm_multi_ch;
  localparam int N_CH    = 4;
  localparam int SEC_W   = 17;
  localparam int DAY_SEC = 86400;

  logic sec_clk = 1'b0;
  logic rst_n   = 1'b1;
  logic [2*N_CH-1:0] state_dbg;

  alarm_multi_ch_if #(.N_CH(N_CH), .SEC_W(SEC_W)) bus ();

  alarm_multi_ch #(.N_CH(N_CH), .SEC_W(SEC_W)) dut (
    .sec_clk   (sec_clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  always #5 sec_clk = ~sec_clk;

  logic [6:0] exp_q[$];
  string      tag_q[$];
  int         checks   = 0;
  int         failures = 0;

  function automatic logic [6:0] pack_exp(input logic [3:0] al);
    logic [1:0] ch;
    ch = 2'd0;
    for (int i = 3; i >= 0; i--) if (al[i]) ch = 2'(i);
    return {al, |al, ch};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got alarming=%b any=%b active_ch=%0d, expected alarming=%b any=%b active_ch=%0d",
               name, act[6:3], act[2], act[1:0], exp[6:3], exp[2], exp[1:0]);
    end
  endtask

  // one sec_clk edge: inputs applied at the falling edge, expectation queued for the next rise
  task automatic tick(input string tag, input int cs, input logic [3:0] en,
                      input logic [3:0] al, input logic o, input logic s);
    @(negedge sec_clk);
    bus.cur_sec = SEC_W'(cs);
    bus.enable  = en;
    bus.off     = o;
    bus.snooze  = s;
    exp_q.push_back(pack_exp(al));
    tag_q.push_back($sformatf("%s@%0d", tag, cs));
  endtask

  task automatic seg(input string tag, input int cs0, input int n, input logic [3:0] en,
                     input logic [3:0] al, input logic o_first, input logic s_first);
    for (int i = 0; i < n; i++)
      tick(tag, cs0 + i, en, al, o_first && (i == 0), s_first && (i == 0));
  endtask

  task automatic set_ch(input int ch, input int tar, input int ln);
    bus.tar_sec[ch*SEC_W +: SEC_W] = SEC_W'(tar);
    bus.len_s[2*ch +: 2]           = 2'(ln);
  endtask

  initial begin : monitor
    logic [6:0] e;
    string      t;
    forever begin
      @(posedge sec_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {bus.alarming, bus.any_alarming, bus.active_ch}, e);
      end
    end
  end

  initial begin : stimulus
    int cs;
    bus.cur_sec = '0;
    bus.tar_sec = '0;
    bus.len_s   = '0;
    bus.enable  = '0;
    bus.off     = 1'b0;
    bus.snooze  = 1'b0;

    #2 rst_n = 1'b0;
    #1 check("reset", {bus.alarming, bus.any_alarming, bus.active_ch}, 7'd0);
    repeat (2) @(posedge sec_clk);
    set_ch(0, 100, 0);
    @(negedge sec_clk);
    rst_n = 1'b1;

    // basic 16-edge window; mid-ring length change has no effect
    for (cs = 95; cs <= 120; cs++) begin
      tick("t1", cs, 4'b0001, (cs >= 100 && cs <= 115) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
      if (cs == 105) set_ch(0, 100, 3);
    end

    // window wrapping through midnight, 31 edges
    set_ch(1, 86390, 1);
    for (int k = 0; k < 41; k++) begin
      cs = (86385 + k) % DAY_SEC;
      tick("t2", cs, 4'b0010, (cs >= 86390 || cs <= 20) ? 4'b0010 : 4'b0000, 1'b0, 1'b0);
    end

    // dismiss, then re-match, then off+snooze together
    set_ch(0, 300, 0);
    seg("t3_pre",  298, 2,   4'b0001, 4'b0000, 1'b0, 1'b0);
    seg("t3_ring", 300, 5,   4'b0001, 4'b0001, 1'b0, 1'b0);
    seg("t3_off",  305, 16,  4'b0001, 4'b0000, 1'b1, 1'b0);
    tick("t3_away", 299, 4'b0001, 4'b0000, 1'b0, 1'b0);
    tick("t3_rematch", 300, 4'b0001, 4'b0001, 1'b0, 1'b0);
    seg("t3_offsnz", 301, 320, 4'b0001, 4'b0000, 1'b1, 1'b1);

    // no re-trigger while cur_sec stays on the target; enable low silences
    set_ch(0, 400, 0);
    tick("nr_trig",  400, 4'b0001, 4'b0001, 1'b0, 1'b0);
    tick("nr_off",   400, 4'b0001, 4'b0000, 1'b1, 1'b0);
    tick("nr_hold",  400, 4'b0001, 4'b0000, 1'b0, 1'b0);
    tick("nr_leave", 401, 4'b0001, 4'b0000, 1'b0, 1'b0);
    tick("nr_again", 400, 4'b0001, 4'b0001, 1'b0, 1'b0);
    tick("en_low",   401, 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick("en_low2",  402, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // two channels, shared off, active_ch priority
    set_ch(0, 200, 0);
    set_ch(2, 200, 0);
    seg("t5_pre",  198, 2, 4'b0101, 4'b0000, 1'b0, 1'b0);
    seg("t5_both", 200, 2, 4'b0101, 4'b0101, 1'b0, 1'b0);
    seg("t5_off",  202, 3, 4'b0101, 4'b0000, 1'b1, 1'b0);
    set_ch(2, 500, 0);
    set_ch(0, 502, 0);
    tick("t5_c2pre", 499, 4'b0100, 4'b0000, 1'b0, 1'b0);
    seg("t5_c2",   500, 2, 4'b0100, 4'b0100, 1'b0, 1'b0);
    seg("t5_c02",  502, 2, 4'b0101, 4'b0101, 1'b0, 1'b0);
    tick("t5_off2", 504, 4'b0101, 4'b0000, 1'b1, 1'b0);

    // out-of-range target never triggers
    set_ch(3, 100000, 0);
    tick("bad_tar", 100000, 4'b1000, 4'b0000, 1'b0, 1'b0);
    tick("bad_tar2", 505, 4'b1000, 4'b0000, 1'b0, 1'b0);

    // asynchronous reset in the middle of a ring
    set_ch(0, 600, 0);
    seg("t6_pre",  598, 2, 4'b0001, 4'b0000, 1'b0, 1'b0);
    seg("t6_ring", 600, 3, 4'b0001, 4'b0001, 1'b0, 1'b0);
    @(negedge sec_clk);
    #2 rst_n = 1'b0;
    #1 check("rst_mid", {bus.alarming, bus.any_alarming, bus.active_ch}, 7'd0);
    @(negedge sec_clk);
    bus.cur_sec = SEC_W'(603);
    rst_n = 1'b1;
    seg("t6_after", 603, 18, 4'b0001, 4'b0000, 1'b0, 1'b0);
    tick("t6_rering", 600, 4'b0001, 4'b0001, 1'b0, 1'b0);
    tick("t6_en_low", 601, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // snooze
    set_ch(0, 1000, 0);
    seg("t4_ring", 1000, 3, 4'b0001, 4'b0001, 1'b0, 1'b0);
`ifdef ALARM_SNOOZE_EN
    seg("t4_snz1", 1003, 301, 4'b0001, 4'b0000, 1'b0, 1'b1);
    seg("t4_r1",   1304, 1,   4'b0001, 4'b0001, 1'b0, 1'b0);
    seg("t4_snz2", 1305, 301, 4'b0001, 4'b0000, 1'b0, 1'b1);
    seg("t4_r2",   1606, 1,   4'b0001, 4'b0001, 1'b0, 1'b0);
    seg("t4_snz3", 1607, 301, 4'b0001, 4'b0000, 1'b0, 1'b1);
    seg("t4_r3",   1908, 1,   4'b0001, 4'b0001, 1'b0, 1'b0);
    seg("t4_snz4", 1909, 15,  4'b0001, 4'b0001, 1'b0, 1'b1);
    seg("t4_end",  1924, 3,   4'b0001, 4'b0000, 1'b0, 1'b0);
`else
    seg("t4_nosnz", 1003, 13, 4'b0001, 4'b0001, 1'b0, 1'b1);
    seg("t4_end",   1016, 3,  4'b0001, 4'b0000, 1'b0, 1'b0);
`endif

    repeat (3) @(posedge sec_clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
